simd_issue_sequencer: RTL

//  Sequences the 4-lane SIMD datapath. Accepts one instruction plus a vector count, then streams

---
 rtl/simd_pkg.sv | 27 ++
 rtl/simd_lane_tracker.sv | 27 ++
 rtl/simd_issue_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/simd_pkg.sv
// Shared definitions for the SIMD issue sequencer: lane geometry, opcodes and FSM state encoding.
package simd_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 32;

    localparam logic [2:0] OP_ADD      = 3'b000;
    localparam logic [2:0] OP_SUB      = 3'b001;
    localparam logic [2:0] OP_MUL      = 3'b010;
    localparam logic [2:0] OP_AND      = 3'b011;
    localparam logic [2:0] OP_OR       = 3'b100;
    localparam logic [2:0] OP_XOR      = 3'b101;
    localparam logic [2:0] OP_RSVD_MIN = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    function automatic logic op_reserved(input logic [2:0] op);
        return op >= OP_RSVD_MIN;
    endfunction

endpackage

// File: rtl/simd_lane_tracker.sv
// Sticky per-lane completion mask; all_done also sees the current cycle's pulses.
module simd_lane_tracker #(
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [LANES-1:0] dp_done,
    output logic             all_done
);

    logic [LANES-1:0] mask;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask <= '0;
        end else if (clear) begin
            mask <= '0;
        end else if (en) begin
            mask <= mask | dp_done;
        end
    end

    assign all_done = &(mask | dp_done);

endmodule

// File: rtl/simd_issue_sequencer.sv
// Issues operand pairs to the 4-lane SIMD datapath and waits for all lanes per vector.
// Optional WAIT watchdog enabled by defining SIMD_SEQ_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | ready for an instruction
// FETCH   | ready for an operand pair
// ISSUE   | operands latched, start strobe follows
// WAIT    | collecting lane completions
// DONE    | job finished, end-of-job pulse follows
module simd_issue_sequencer #(
    parameter int LANES  = 4,
    parameter int LANE_W = 32,
    parameter int CNT_W  = 6
`ifdef SIMD_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 255
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_instruction,
    input  logic [2:0]              instruction,
    input  logic [CNT_W-1:0]        data_size,
    output logic                    instr_ready,
    input  logic                    valid_data,
    output logic                    data_ready,
    input  logic [LANES*LANE_W-1:0] mc_data_in_opa,
    input  logic [LANES*LANE_W-1:0] mc_data_in_opb,
    output logic                    dp_start,
    output logic [2:0]              dp_op,
    output logic [LANES*LANE_W-1:0] dp_opa,
    output logic [LANES*LANE_W-1:0] dp_opb,
    input  logic [LANES-1:0]        dp_done,
    output logic                    busy,
    output logic [CNT_W-1:0]        vec_cnt,
    output logic                    job_done,
    output logic                    err_illegal,
    output logic                    err_timeout
);
    import simd_pkg::*;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] remaining;
    logic             all_done, accept, reserved, last_vec, timed_out;

    assign accept   = (state == S_IDLE) && valid_instruction;
    assign reserved = op_reserved(instruction);
    assign last_vec = (remaining == CNT_W'(1));

    simd_lane_tracker #(.LANES(LANES)) u_tracker (
        .clk      (clk),
        .reset    (reset),
        .clear    (state == S_ISSUE),
        .en       (state == S_WAIT),
        .dp_done  (dp_done),
        .all_done (all_done)
    );

`ifdef SIMD_SEQ_TIMEOUT_EN
    logic [7:0] wd;
    logic       to_seen;

    // to_seen remembers that DONE was reached through the watchdog so the error lines up with job_done
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd          <= '0;
            to_seen     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= (state == S_DONE) && to_seen;
            if (state == S_ISSUE)     wd <= '0;
            else if (state == S_WAIT) wd <= wd + 8'd1;
            if (timed_out)            to_seen <= 1'b1;
            else if (state == S_DONE) to_seen <= 1'b0;
        end
    end

    assign timed_out = (state == S_WAIT) && !all_done && (wd == 8'(TIMEOUT - 1));
`else
    assign timed_out   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && !reserved)
                         state_nxt = (data_size == '0) ? S_DONE : S_FETCH;
            S_FETCH: if (valid_data) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (all_done)       state_nxt = last_vec ? S_DONE : S_FETCH;
                     else if (timed_out) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state == S_IDLE);
        data_ready  = (state == S_FETCH);
        busy        = (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dp_start    <= 1'b0;
            dp_op       <= '0;
            dp_opa      <= '0;
            dp_opb      <= '0;
            vec_cnt     <= '0;
            remaining   <= '0;
            job_done    <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            dp_start    <= (state == S_ISSUE);
            job_done    <= (state == S_DONE);
            err_illegal <= accept && reserved;
            if (accept && !reserved) begin
                dp_op     <= instruction;
                remaining <= data_size;
                vec_cnt   <= '0;
            end
            if ((state == S_FETCH) && valid_data) begin
                dp_opa <= mc_data_in_opa;
                dp_opb <= mc_data_in_opb;
            end
            if (state == S_ISSUE) vec_cnt <= vec_cnt + CNT_W'(1);
            if ((state == S_WAIT) && all_done && !last_vec) remaining <= remaining - CNT_W'(1);
        end
    end

endmodule
